iomem_sram_denetleyici: RTL
===========================

Name: iomem_sram_denetleyici

Overview:
- Memory-side controller that answers the processor's iomem valid/ready bus (valid, wstrb, addr, wdata / ready, rdata).
- Drives a single-port, word-organised SRAM macro with byte write mask and a fixed, parameterised read latency.
- Sits directly downstream of the processor top-level, in place of the external main memory.
- Out-of-window addresses are answered with an error response; no SRAM access is made for them.

Parameters:
ADRES_BIT, 10, SRAM word-address width (SRAM depth = 2**ADRES_BIT words of 32 bits)
TABAN_ADRES, 32'h4000_0000, byte base address of the SRAM window
BEKLEME, 1, SRAM read latency in cycles from the cs cycle to valid rdata (must be >= 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
iomem_valid_i  in  1  request valid; held by master until ready sampled high
iomem_wstrb_i  in  4  byte write strobes; 0 = read
iomem_addr_i  in  32  byte address
iomem_wdata_i  in  32  write data
iomem_ready_o  out  1  one-cycle completion pulse
iomem_rdata_o  out  32  read data, valid while ready_o=1
hata_o  out  1  one-cycle pulse with ready_o for an out-of-window access
sram_cs_o  out  1  SRAM chip select
sram_we_o  out  1  SRAM write enable
sram_wmask_o  out  4  SRAM byte write mask
sram_adres_o  out  ADRES_BIT  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data

Behaviour:
- Reset is asynchronous and active-high. One clock, clk_i.
- Reset values: all outputs 0, state BOSTA, internal latches 0.
- Window: a request is in window when iomem_addr_i - TABAN_ADRES < 4*2**ADRES_BIT, computed unsigned and 32-bit.
- SRAM word address: (addr - TABAN_ADRES)[ADRES_BIT+1:2]. addr[1:0] is ignored.
- States: BOSTA, ERISIM, BEKLE, YANIT, HATA.
- BOSTA:
  - When iomem_valid_i=1, latch addr, wdata and wstrb.
  - In window: go to ERISIM. Out of window: go to HATA.
  - When iomem_valid_i=0, stay in BOSTA.
- ERISIM (one cycle):
  - sram_cs_o=1, sram_adres_o and sram_wdata_o from the latches.
  - sram_we_o = |wstrb, sram_wmask_o = wstrb.
  - Write: next state YANIT. Read: next state BEKLE, with the wait counter loaded to BEKLEME-1.
- BEKLE:
  - cs=0. Count down each cycle.
  - When the counter is 0: register sram_rdata_i into the rdata latch and go to YANIT.
  - With BEKLEME=1, BEKLE lasts exactly one cycle.
- YANIT (one cycle):
  - iomem_ready_o=1.
  - iomem_rdata_o = latched read data for a read, 0 for a write.
  - Next state BOSTA.
- HATA (one cycle):
  - iomem_ready_o=1, hata_o=1, iomem_rdata_o=32'h0, no SRAM activity.
  - Next state BOSTA.
- Latency: count cycles from the edge at which BOSTA accepts valid to the ready_o cycle.
  - Write: 2 cycles.
  - Read: 2+BEKLEME cycles.
  - Out of window: 1 cycle.
- Outputs outside their active states:
  - ready_o, hata_o, sram_cs_o, sram_we_o and sram_wmask_o are 0.
  - iomem_rdata_o is 0 except in YANIT/HATA.
- Back-to-back requests:
  - valid re-sampled high in BOSTA immediately after YANIT starts a new transaction with no bubble beyond BOSTA.
  - The master must deassert valid (or present a new request) after seeing ready.
- valid dropped mid-transaction: ignored. The transaction completes, including the SRAM write, and ready still pulses.
- Request inputs changing after acceptance: ignored. The latched values are used.
- Reset mid-transaction: cs/we fall immediately (asynchronous), no ready is issued, and the aborted transaction is lost.
- wstrb partial, e.g. 4'b0100: only that byte lane is written. Read-back returns the full word.

Test Plan:
- Write then read: write addr 32'h4000_0010, wdata 32'hA5A5_1234, wstrb 4'hF -> ERISIM cs=1 we=1 sram_adres=4, ready 2 cycles after accept. Read same addr -> ready at 3 cycles (BEKLEME=1), rdata 32'hA5A5_1234.
- Byte write: over 32'h1122_3344 at word 4, write wstrb 4'b0010 with wdata 32'h0000_AB00 -> sram_wmask=4'b0010. Read-back 32'h1122_AB44.
- Out of window: read 32'h3FFF_FFFC and 32'h4000_1000 (ADRES_BIT=10) -> ready plus hata_o after 1 cycle, rdata 0, sram_cs never asserted.
- Latency sweep: BEKLEME=3 -> read ready exactly 5 cycles after accept, rdata captured from the SRAM model's delayed output.
- Back-to-back: a write then a read issued the cycle after ready -> two ready pulses, correct data. Drop valid during BEKLE -> ready still pulses once.
- Reset mid-read: assert rst_i in BEKLE -> all outputs 0 within the same cycle, state BOSTA, no ready. The next read completes normally.

Source files
------------

// File: rtl/iomem_sram_denetleyici.sv
// iomem_sram_denetleyici
// Answers the processor's iomem valid/ready bus from a single-port, word-wide
// SRAM macro with a byte write mask and a fixed read latency. Requests outside
// the SRAM address window get an immediate error response and never reach
// the SRAM. All outputs are registered; next values are computed from the
// next state so that each output lines up with the state it belongs to.

module iomem_sram_denetleyici #(
  parameter int unsigned ADRES_BIT   = 10,
  parameter logic [31:0] TABAN_ADRES = 32'h4000_0000,
  parameter int unsigned BEKLEME     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iomem_valid_i,
  input  logic [3:0]           iomem_wstrb_i,
  input  logic [31:0]          iomem_addr_i,
  input  logic [31:0]          iomem_wdata_i,
  output logic                 iomem_ready_o,
  output logic [31:0]          iomem_rdata_o,
  output logic                 hata_o,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [3:0]           sram_wmask_o,
  output logic [ADRES_BIT-1:0] sram_adres_o,
  output logic [31:0]          sram_wdata_o,
  input  logic [31:0]          sram_rdata_i
);

  // Window size in bytes; the offset compare below is unsigned, so addresses
  // below the base wrap to huge offsets and fall out of the window.
  localparam logic [31:0] PENCERE_BOY = 32'd4 << ADRES_BIT;

  // Wait counter only has to hold BEKLEME-1.
  localparam int unsigned          SAYAC_BIT = (BEKLEME > 1) ? $clog2(BEKLEME) : 1;
  localparam logic [SAYAC_BIT-1:0] SAYAC_YUK = SAYAC_BIT'(BEKLEME - 1);
  localparam logic [SAYAC_BIT-1:0] SAYAC_SIF = {SAYAC_BIT{1'b0}};
  localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = SAYAC_BIT'(1);

  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    ERISIM = 3'd1,
    BEKLE  = 3'd2,
    YANIT  = 3'd3,
    HATA   = 3'd4
  } durum_t;

  durum_t               durum_r, durum_s;
  logic [SAYAC_BIT-1:0] sayac_r, sayac_s;
  logic [3:0]           wstrb_r;
  logic [31:0]          ofset_s;
  logic                 pencere_ici_s;

  logic                 ready_s;
  logic                 hata_s;
  logic [31:0]          rdata_s;
  logic                 cs_s;
  logic                 we_s;
  logic [3:0]           wmask_s;

  assign ofset_s       = iomem_addr_i - TABAN_ADRES;
  assign pencere_ici_s = (ofset_s < PENCERE_BOY);

  // State and wait-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_r <= BOSTA;
      sayac_r <= SAYAC_SIF;
    end else begin
      durum_r <= durum_s;
      sayac_r <= sayac_s;
    end
  end

  // Next-state logic: accept, access, wait out the read latency, respond.
  always_comb begin
    durum_s = durum_r;
    sayac_s = sayac_r;
    case (durum_r)
      BOSTA: begin
        if (iomem_valid_i) begin
          if (pencere_ici_s) begin
            durum_s = ERISIM;
          end else begin
            durum_s = HATA;
          end
        end else begin
          durum_s = BOSTA;
        end
      end
      ERISIM: begin
        if (|wstrb_r) begin
          durum_s = YANIT;
        end else begin
          durum_s = BEKLE;
          sayac_s = SAYAC_YUK;
        end
      end
      BEKLE: begin
        if (sayac_r == SAYAC_SIF) begin
          durum_s = YANIT;
        end else begin
          sayac_s = sayac_r - SAYAC_BIR;
        end
      end
      YANIT:   durum_s = BOSTA;
      HATA:    durum_s = BOSTA;
      default: durum_s = BOSTA;
    endcase
  end

  // Next output values, derived from the state being entered. The only way
  // into ERISIM is from BOSTA, so the live strobes equal what gets latched.
  always_comb begin
    ready_s = (durum_s == YANIT) || (durum_s == HATA);
    hata_s  = (durum_s == HATA);
    cs_s    = (durum_s == ERISIM);
    if (cs_s) begin
      we_s    = |iomem_wstrb_i;
      wmask_s = iomem_wstrb_i;
    end else begin
      we_s    = 1'b0;
      wmask_s = 4'b0000;
    end
    if ((durum_r == BEKLE) && (sayac_r == SAYAC_SIF)) begin
      rdata_s = sram_rdata_i;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Request latches: word address and write data go straight to the SRAM
  // pins, strobes are kept for the read/write decision in ERISIM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sram_adres_o <= {ADRES_BIT{1'b0}};
      sram_wdata_o <= 32'h0000_0000;
      wstrb_r      <= 4'b0000;
    end else if ((durum_r == BOSTA) && iomem_valid_i) begin
      sram_adres_o <= ofset_s[ADRES_BIT+1:2];
      sram_wdata_o <= iomem_wdata_i;
      wstrb_r      <= iomem_wstrb_i;
    end else begin
      sram_adres_o <= sram_adres_o;
      sram_wdata_o <= sram_wdata_o;
      wstrb_r      <= wstrb_r;
    end
  end

  // Registered bus and SRAM control outputs; the read-data register doubles
  // as the read-data latch, holding the word for the single YANIT cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iomem_ready_o <= 1'b0;
      hata_o        <= 1'b0;
      iomem_rdata_o <= 32'h0000_0000;
      sram_cs_o     <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_wmask_o  <= 4'b0000;
    end else begin
      iomem_ready_o <= ready_s;
      hata_o        <= hata_s;
      iomem_rdata_o <= rdata_s;
      sram_cs_o     <= cs_s;
      sram_we_o     <= we_s;
      sram_wmask_o  <= wmask_s;
    end
  end

endmodule
